pkg_wr_ctrl: RTL and testbench

Write-side controller for the dual-priority packet buffer. It accepts a byte-stream packet interface (valid, sop, eop, qos) and writes each packet into the high-priority RAM (qos=1) or the low-priority RAM (qos=0). It publishes committed write pointers (high_real_waddr, low_real_waddr) that move only at packet boundaries, so the downstream read controller never sees a partial packet. Packets that do not fit, and malformed packets, are dropped whole.

---
 rtl/pkg_wr_ctrl_pkg.sv | 29 ++
 rtl/pkg_wr_ctrl_wr_ptr.sv | 67 ++++++
 rtl/pkg_wr_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pkg_wr_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_wr_ctrl_pkg.sv
// Shared definitions for the dual-priority packet buffer: RAM word layout,
// default geometry and write-controller FSM states.
package pkg_wr_ctrl_pkg;

    localparam int RAM_DEPTH   = 256;
    localparam int ADDR_WIDTH  = 8;
    localparam int MAX_PKT_LEN = 64;

    localparam int DATA_LSB = 0;
    localparam int EOP_BIT  = 8;
    localparam int SOP_BIT  = 9;
    localparam int QOS_BIT  = 10;
    localparam int WORD_W   = 11;

    // Field order matches the bit positions above (qos is the MSB)
    typedef struct packed {
        logic       qos;
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } ram_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_DROP
    } wr_state_t;

endpackage

// File: rtl/pkg_wr_ctrl_wr_ptr.sv
// Per-RAM pointer pair: speculative write pointer plus committed pointer,
// with wrap, rewind, commit and free-space computation.
module pkg_wr_ptr
    import pkg_wr_ctrl_pkg::*;
#(
    parameter int RAM_DEPTH  = pkg_wr_ctrl_pkg::RAM_DEPTH,
    parameter int ADDR_WIDTH = pkg_wr_ctrl_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  start,
    input  logic                  inc,
    input  logic                  rewind,
    input  logic                  commit,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] real_waddr,
    output logic [ADDR_WIDTH:0]   free
);

    localparam int LAST_I  = RAM_DEPTH - 1;
    localparam int DEPTH_I = RAM_DEPTH;
    localparam logic [ADDR_WIDTH-1:0] LAST    = LAST_I[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   LAST_E  = LAST_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   DEPTH_E = DEPTH_I[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wptr, cptr, cptr_d1;
    logic [ADDR_WIDTH-1:0] base, nxt;
    logic [ADDR_WIDTH:0]   occ;

    // A new packet (or an abort) always restarts from the committed pointer
    assign base = (start | rewind) ? cptr : wptr;
    assign nxt  = (base == LAST) ? '0 : base + ADDR_WIDTH'(1);
    assign addr = base;

    always_comb begin
        occ = '0;
        if (cptr >= raddr)
            occ = {1'b0, cptr} - {1'b0, raddr};
        else
            occ = {1'b0, cptr} + DEPTH_E - {1'b0, raddr};
    end

    // Free space is taken from the committed pointer: at every sop decision
    // the speculative pointer either equals it or is being rewound to it.
    assign free = LAST_E - occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            cptr       <= '0;
            cptr_d1    <= '0;
            real_waddr <= '0;
        end else begin
            if (start | inc)
                wptr <= nxt;
            else if (rewind)
                wptr <= cptr;
            if (commit)
                cptr <= nxt;
            // Published pointer trails by two edges so it never leads RAM content
            cptr_d1    <= cptr;
            real_waddr <= cptr_d1;
        end
    end

endmodule

// File: rtl/pkg_wr_ctrl.sv
// Write-side controller: steers byte-stream packets into the high or low
// priority RAM, committing pointers only at packet boundaries.
module pkg_wr_ctrl
    import pkg_wr_ctrl_pkg::*;
#(
    parameter int RAM_DEPTH   = pkg_wr_ctrl_pkg::RAM_DEPTH,
    parameter int ADDR_WIDTH  = pkg_wr_ctrl_pkg::ADDR_WIDTH,
    parameter int MAX_PKT_LEN = pkg_wr_ctrl_pkg::MAX_PKT_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chx_vld_in,
    input  logic [7:0]            chx_data_in,
    input  logic                  chx_sop_in,
    input  logic                  chx_eop_in,
    input  logic                  chx_qos_in,
    input  logic [ADDR_WIDTH-1:0] hram_raddr,
    input  logic [ADDR_WIDTH-1:0] lram_raddr,
    output logic                  hram_wen,
    output logic [ADDR_WIDTH-1:0] hram_waddr,
    output logic [WORD_W-1:0]     hram_wdata,
    output logic                  lram_wen,
    output logic [ADDR_WIDTH-1:0] lram_waddr,
    output logic [WORD_W-1:0]     lram_wdata,
    output logic [ADDR_WIDTH-1:0] high_real_waddr,
    output logic [ADDR_WIDTH-1:0] low_real_waddr,
    output logic                  pkt_drop,
    output logic [15:0]           drop_cnt
);

    localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT_LEN);

    wr_state_t        state, state_nxt;
    logic             sel, sel_nxt;
    logic [LEN_W-1:0] len, len_nxt;

    // Index 1 = high-priority RAM, index 0 = low-priority RAM
    logic [1:0]            start, inc, rewind, commit;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [ADDR_WIDTH-1:0] rptr  [2];
    logic [ADDR_WIDTH-1:0] raddr [2];
    logic [ADDR_WIDTH:0]   free  [2];

    logic       wr, wr_hi, sop_path;
    logic [1:0] drops;
    ram_word_t  wr_word;
    logic [16:0] cnt_sum;

    assign raddr[1] = hram_raddr;
    assign raddr[0] = lram_raddr;

    for (genvar i = 0; i < 2; i++) begin : g_ptr
        pkg_wr_ptr #(
            .RAM_DEPTH (RAM_DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ptr (
            .clk       (clk),
            .rst       (rst),
            .raddr     (raddr[i]),
            .start     (start[i]),
            .inc       (inc[i]),
            .rewind    (rewind[i]),
            .commit    (commit[i]),
            .addr      (addr[i]),
            .real_waddr(rptr[i]),
            .free      (free[i])
        );
    end

    assign high_real_waddr = rptr[1];
    assign low_real_waddr  = rptr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= 1'b0;
            len   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            len   <= len_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        len_nxt   = len;
        start     = '0;
        inc       = '0;
        rewind    = '0;
        commit    = '0;
        wr        = 1'b0;
        wr_hi     = sel;
        sop_path  = 1'b0;
        drops     = '0;
        wr_word   = '{qos: 1'b0, sop: 1'b0, eop: chx_eop_in, data: chx_data_in};

        if (chx_vld_in) begin
            unique case (state)
                ST_IDLE: sop_path = chx_sop_in;
                ST_WR: begin
                    if (chx_sop_in) begin
                        // sop before eop: abort, then reuse this beat as a fresh sop
                        rewind[sel] = 1'b1;
                        drops       = drops + 2'd1;
                        sop_path    = 1'b1;
                    end else if (len == LEN_MAX) begin
                        rewind[sel] = 1'b1;
                        drops       = drops + 2'd1;
                        state_nxt   = chx_eop_in ? ST_IDLE : ST_DROP;
                    end else begin
                        inc[sel] = 1'b1;
                        wr       = 1'b1;
                        len_nxt  = len + LEN_W'(1);
                        if (chx_eop_in) begin
                            commit[sel] = 1'b1;
                            state_nxt   = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (chx_sop_in)
                        sop_path = 1'b1;
                    else if (chx_eop_in)
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase

            if (sop_path) begin
                if (int'(free[chx_qos_in]) >= MAX_PKT_LEN) begin
                    start[chx_qos_in] = 1'b1;
                    wr                = 1'b1;
                    wr_hi             = chx_qos_in;
                    wr_word.sop       = 1'b1;
                    sel_nxt           = chx_qos_in;
                    len_nxt           = LEN_W'(1);
                    if (chx_eop_in) begin
                        commit[chx_qos_in] = 1'b1;
                        state_nxt          = ST_IDLE;
                    end else begin
                        state_nxt = ST_WR;
                    end
                end else begin
                    drops     = drops + 2'd1;
                    state_nxt = chx_eop_in ? ST_IDLE : ST_DROP;
                end
            end
        end
        wr_word.qos = wr_hi;
    end

    assign cnt_sum = {1'b0, drop_cnt} + 17'(drops);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hram_wen   <= 1'b0;
            hram_waddr <= '0;
            hram_wdata <= '0;
            lram_wen   <= 1'b0;
            lram_waddr <= '0;
            lram_wdata <= '0;
            pkt_drop   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            hram_wen <= wr & wr_hi;
            lram_wen <= wr & ~wr_hi;
            if (wr & wr_hi) begin
                hram_waddr <= addr[1];
                hram_wdata <= wr_word;
            end
            if (wr & ~wr_hi) begin
                lram_waddr <= addr[0];
                lram_wdata <= wr_word;
            end
            pkt_drop <= |drops;
            drop_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

endmodule

// File: tb/tb_pkg_wr_ctrl.sv
// Directed bench for pkg_wr_ctrl: packet writes, commit latency, wrap,
// full drop, aborted/overlong packets and reset mid-packet.
module tb_pkg_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld, sop, eop, qos;
    logic [7:0]  data;
    logic [7:0]  hram_raddr, lram_raddr;
    logic        hram_wen, lram_wen;
    logic [7:0]  hram_waddr, lram_waddr;
    logic [10:0] hram_wdata, lram_wdata;
    logic [7:0]  high_real_waddr, low_real_waddr;
    logic        pkt_drop;
    logic [15:0] drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pkg_wr_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .chx_vld_in     (vld),
        .chx_data_in    (data),
        .chx_sop_in     (sop),
        .chx_eop_in     (eop),
        .chx_qos_in     (qos),
        .hram_raddr     (hram_raddr),
        .lram_raddr     (lram_raddr),
        .hram_wen       (hram_wen),
        .hram_waddr     (hram_waddr),
        .hram_wdata     (hram_wdata),
        .lram_wen       (lram_wen),
        .lram_waddr     (lram_waddr),
        .lram_wdata     (lram_wdata),
        .high_real_waddr(high_real_waddr),
        .low_real_waddr (low_real_waddr),
        .pkt_drop       (pkt_drop),
        .drop_cnt       (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat before an edge; return just after that edge
    task automatic send(input logic s, input logic e, input logic q, input logic [7:0] d);
        @(negedge clk);
        vld = 1'b1; sop = s; eop = e; qos = q; data = d;
        @(posedge clk);
        #1;
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int hp;
    int len;

    initial begin
        rst = 1'b1; vld = 1'b0; sop = 1'b0; eop = 1'b0; qos = 1'b0; data = '0;
        hram_raddr = '0; lram_raddr = '0;
        #1;
        check("rst_hwen",  hram_wen, 0);
        check("rst_lwen",  lram_wen, 0);
        check("rst_hreal", high_real_waddr, 0);
        check("rst_dcnt",  drop_cnt, 0);
        check("rst_drop",  pkt_drop, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 3-byte high packet
        send(1, 0, 1, 8'hA1);
        check("p1_b0_wen",  hram_wen, 1);
        check("p1_b0_addr", hram_waddr, 0);
        check("p1_b0_data", hram_wdata, 11'h6A1);
        check("p1_b0_lwen", lram_wen, 0);
        send(0, 0, 1, 8'hA2);
        check("p1_b1_addr", hram_waddr, 1);
        check("p1_b1_data", hram_wdata, 11'h4A2);
        send(0, 1, 1, 8'hA3);
        check("p1_b2_addr", hram_waddr, 2);
        check("p1_b2_data", hram_wdata, 11'h5A3);
        check("p1_real_e0", high_real_waddr, 0);
        idle(1);
        check("p1_wen_off", hram_wen, 0);
        check("p1_real_e1", high_real_waddr, 0);
        idle(1);
        check("p1_real_e2", high_real_waddr, 3);
        check("p1_lreal",   low_real_waddr, 0);

        // single-beat low packet
        send(1, 1, 0, 8'h55);
        check("p2_lwen",  lram_wen, 1);
        check("p2_laddr", lram_waddr, 0);
        check("p2_ldata", lram_wdata, 11'h355);
        check("p2_hwen",  hram_wen, 0);
        idle(2);
        check("p2_lreal", low_real_waddr, 1);

        // beat without sop while idle is discarded silently
        send(0, 0, 1, 8'h99);
        check("stray_wen",  hram_wen, 0);
        check("stray_drop", pkt_drop, 0);

        // fill and drain the high RAM up to address 254
        hp = 3;
        while (hp != 254) begin
            len = (254 - hp > 64) ? 64 : 254 - hp;
            for (int i = 0; i < len; i++)
                send(i == 0, i == len - 1, 1, i[7:0]);
            hp += len;
            idle(2);
            check("drain_real", high_real_waddr, hp);
            hram_raddr = hp[7:0];
        end

        // wrap across the top of the high RAM
        for (int k = 0; k < 4; k++) begin
            send(k == 0, k == 3, 1, 8'hB0 + k[7:0]);
            check("wrap_addr", hram_waddr, (254 + k) % 256);
        end
        idle(2);
        check("wrap_real", high_real_waddr, 2);

        // occupancy 200 -> free 55: dropped whole
        hram_raddr = 8'd58;
        send(1, 0, 1, 8'hC0);
        check("full_drop", pkt_drop, 1);
        check("full_wen",  hram_wen, 0);
        check("full_dcnt", drop_cnt, 1);
        send(0, 0, 1, 8'hC1);
        check("full_drop_once", pkt_drop, 0);
        check("full_wen2", hram_wen, 0);
        send(0, 1, 1, 8'hC2);
        check("full_wen3", hram_wen, 0);
        idle(2);
        check("full_real", high_real_waddr, 2);

        // occupancy 191 -> free exactly 64: accepted
        hram_raddr = 8'd67;
        send(1, 1, 1, 8'hD0);
        check("edge_wen",  hram_wen, 1);
        check("edge_addr", hram_waddr, 2);
        check("edge_drop", pkt_drop, 0);
        idle(2);
        check("edge_real", high_real_waddr, 3);
        hram_raddr = 8'd3;

        // 5 beats without eop, then a new 2-byte packet
        for (int k = 0; k < 5; k++) begin
            send(k == 0, 0, 1, 8'hE0 + k[7:0]);
            check("abort_addr", hram_waddr, 3 + k);
        end
        check("abort_real0", high_real_waddr, 3);
        send(1, 0, 1, 8'hF0);
        check("abort_drop", pkt_drop, 1);
        check("abort_dcnt", drop_cnt, 2);
        check("abort_wen",  hram_wen, 1);
        check("abort_addr_new", hram_waddr, 3);
        check("abort_data", hram_wdata, 11'h6F0);
        send(0, 1, 1, 8'hF1);
        check("abort_addr2", hram_waddr, 4);
        check("abort_data2", hram_wdata, 11'h5F1);
        idle(2);
        check("abort_real", high_real_waddr, 5);

        // 65-byte low packet: the 65th beat drops it
        lram_raddr = 8'd1;
        for (int k = 0; k < 64; k++) begin
            send(k == 0, 0, 0, k[7:0]);
            if (k == 63) check("long_addr63", lram_waddr, 64);
        end
        send(0, 1, 0, 8'hEE);
        check("long_drop", pkt_drop, 1);
        check("long_wen",  lram_wen, 0);
        check("long_dcnt", drop_cnt, 3);
        idle(2);
        check("long_real", low_real_waddr, 1);
        send(1, 1, 0, 8'h77);
        check("long_next_addr", lram_waddr, 1);
        idle(2);
        check("long_next_real", low_real_waddr, 2);

        // reset in the middle of a high packet
        hram_raddr = 8'd5;
        for (int k = 0; k < 3; k++) send(k == 0, 0, 1, 8'h30 + k[7:0]);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_wen",   hram_wen, 0);
        check("mid_rst_addr",  hram_waddr, 0);
        check("mid_rst_data",  hram_wdata, 0);
        check("mid_rst_hreal", high_real_waddr, 0);
        check("mid_rst_lreal", low_real_waddr, 0);
        check("mid_rst_dcnt",  drop_cnt, 0);
        hram_raddr = '0; lram_raddr = '0;
        @(negedge clk);
        rst = 1'b0;
        send(1, 1, 1, 8'h11);
        check("post_rst_wen",  hram_wen, 1);
        check("post_rst_addr", hram_waddr, 0);
        check("post_rst_data", hram_wdata, 11'h711);
        idle(2);
        check("post_rst_real", high_real_waddr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
